// File: rtl/pmem_burst_arbiter.sv
// Arbitrates NUM_PORTS line-granular cache-miss requesters onto a single burst
// physical-memory port, serialising each line into LINE_BITS/BURST_BITS beats.
module pmem_burst_arbiter #(
  parameter int NUM_PORTS  = 2,
  parameter int LINE_BITS  = 256,
  parameter int BURST_BITS = 64,
  parameter int ARB_MODE   = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_PORTS-1:0]           req_read,
  input  logic [NUM_PORTS-1:0]           req_write,
  input  logic [NUM_PORTS*32-1:0]        req_address,
  input  logic [NUM_PORTS*LINE_BITS-1:0] req_wdata,
  output logic [LINE_BITS-1:0]           req_rdata,
  output logic [NUM_PORTS-1:0]           req_resp,
  output logic                           pmem_read,
  output logic                           pmem_write,
  output logic [31:0]                    pmem_address,
  output logic [BURST_BITS-1:0]          pmem_wdata,
  input  logic [BURST_BITS-1:0]          pmem_rdata,
  input  logic                           pmem_resp
);

  localparam int BEATS  = LINE_BITS / BURST_BITS;
  localparam int OFFSET = $clog2(LINE_BITS / 8);
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int GNT_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [31:0]       ADDR_MASK = ~((32'd1 << OFFSET) - 32'd1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t               state_q, state_d;
  logic [GNT_W-1:0]     grant_q, last_grant_q, arb_idx;
  logic                 arb_found;
  int                   arb_p;
  logic [31:0]          arb_addr, addr_q;
  logic [BEAT_W-1:0]    beat_q;
  logic                 beat_done;
  logic [LINE_BITS-1:0] line_buf_q, line_next, rdata_q;
  int                   wdata_lsb;

  // Round-robin searches from the port after the last one served; fixed
  // priority always searches from port 0.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    arb_p     = 0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (ARB_MODE == 1) begin
        arb_p = k;
      end else begin
        arb_p = int'(last_grant_q) + 1 + k;
        if (arb_p >= NUM_PORTS) arb_p = arb_p - NUM_PORTS;
      end
      if (!arb_found && (req_read[arb_p] || req_write[arb_p])) begin
        arb_found = 1'b1;
        arb_idx   = GNT_W'(arb_p);
      end
    end
    arb_addr = req_address[32*int'(arb_idx) +: 32];
  end

  assign beat_done = pmem_resp && (beat_q == LAST_BEAT);

  always_comb begin
    line_next = line_buf_q;
    line_next[int'(beat_q)*BURST_BITS +: BURST_BITS] = pmem_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    pmem_wdata = '0;
    req_resp   = '0;
    wdata_lsb  = int'(grant_q) * LINE_BITS + int'(beat_q) * BURST_BITS;
    unique case (state_q)
      IDLE: begin
        // A port raising both bits is treated as a write.
        if (arb_found) state_d = req_write[arb_idx] ? WRITE : READ;
      end
      READ: begin
        pmem_read = 1'b1;
        if (beat_done) state_d = DONE;
      end
      WRITE: begin
        pmem_write = 1'b1;
        pmem_wdata = req_wdata[wdata_lsb +: BURST_BITS];
        if (beat_done) state_d = DONE;
      end
      DONE: begin
        req_resp[grant_q] = 1'b1;
        state_d           = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant_q      <= '0;
      last_grant_q <= GNT_W'(NUM_PORTS - 1);
      beat_q       <= '0;
      addr_q       <= '0;
      rdata_q      <= '0;
    end else begin
      if (state_q == IDLE && arb_found) begin
        grant_q <= arb_idx;
        addr_q  <= arb_addr & ADDR_MASK;
        beat_q  <= '0;
      end
      if ((state_q == READ || state_q == WRITE) && pmem_resp) begin
        beat_q <= beat_q + 1'b1;
        if (beat_q == LAST_BEAT) last_grant_q <= grant_q;
        // Publish the whole line only once it is complete, so req_rdata
        // keeps the previous line during a read in progress.
        if (state_q == READ && beat_q == LAST_BEAT) rdata_q <= line_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == READ && pmem_resp) line_buf_q <= line_next;
  end

  assign pmem_address = addr_q;
  assign req_rdata    = rdata_q;

endmodule

// File: tb/tb_pmem_burst_arbiter.sv
// Directed bench for pmem_burst_arbiter: a 2-port round-robin instance and a
// 3-port fixed-priority instance share the pmem response stimulus.
module tb_pmem_burst_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]   req_read0, req_write0, req_resp0;
  logic [63:0]  req_address0;
  logic [511:0] req_wdata0;
  logic [255:0] req_rdata0;
  logic         pmem_read0, pmem_write0;
  logic [31:0]  pmem_address0;
  logic [63:0]  pmem_wdata0;

  logic [2:0]   req_read1, req_write1, req_resp1;
  logic [95:0]  req_address1;
  logic [767:0] req_wdata1;
  logic [255:0] req_rdata1;
  logic         pmem_read1, pmem_write1;
  logic [31:0]  pmem_address1;
  logic [63:0]  pmem_wdata1;

  logic [63:0]  pmem_rdata;
  logic         pmem_resp;

  int total = 0;
  int bad   = 0;

  pmem_burst_arbiter #(.NUM_PORTS(2), .LINE_BITS(256), .BURST_BITS(64), .ARB_MODE(0)) dut0 (
    .clk(clk), .rst(rst),
    .req_read(req_read0), .req_write(req_write0), .req_address(req_address0),
    .req_wdata(req_wdata0), .req_rdata(req_rdata0), .req_resp(req_resp0),
    .pmem_read(pmem_read0), .pmem_write(pmem_write0), .pmem_address(pmem_address0),
    .pmem_wdata(pmem_wdata0), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  pmem_burst_arbiter #(.NUM_PORTS(3), .LINE_BITS(256), .BURST_BITS(64), .ARB_MODE(1)) dut1 (
    .clk(clk), .rst(rst),
    .req_read(req_read1), .req_write(req_write1), .req_address(req_address1),
    .req_wdata(req_wdata1), .req_rdata(req_rdata1), .req_resp(req_resp1),
    .pmem_read(pmem_read1), .pmem_write(pmem_write1), .pmem_address(pmem_address1),
    .pmem_wdata(pmem_wdata1), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  typedef struct {
    int          port;
    logic [31:0] addr;
    logic [63:0] base;
    logic [31:0] exp_addr;
  } rd_vec_t;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] beat_of(input logic [63:0] base, input int b);
    return base * 64'(b + 1);
  endfunction

  function automatic logic busy(input int d);
    return (d == 0) ? (pmem_read0 | pmem_write0) : (pmem_read1 | pmem_write1);
  endfunction

  function automatic logic rd_of(input int d);
    return (d == 0) ? pmem_read0 : pmem_read1;
  endfunction

  function automatic logic wr_of(input int d);
    return (d == 0) ? pmem_write0 : pmem_write1;
  endfunction

  function automatic logic [7:0] resp_of(input int d);
    return (d == 0) ? 8'(req_resp0) : 8'(req_resp1);
  endfunction

  function automatic logic [255:0] line_of(input int d);
    return (d == 0) ? req_rdata0 : req_rdata1;
  endfunction

  // Waits (bounded) for a burst to start, feeds four back-to-back beats and
  // returns in the DONE cycle with the observed response and read line.
  task automatic serve(input int d, input logic [63:0] base, output logic [7:0] resp,
                       output logic [255:0] line, output logic saw_rd, output logic saw_wr);
    int n;
    n = 0; saw_rd = 1'b0; saw_wr = 1'b0; resp = '0; line = '0;
    while (!busy(d) && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk($sformatf("serve%0d_start", d), 256'(busy(d)), 256'(1));
    if (busy(d)) begin
      for (int b = 0; b < 4; b++) begin
        saw_rd = saw_rd | rd_of(d);
        saw_wr = saw_wr | wr_of(d);
        pmem_rdata = beat_of(base, b);
        pmem_resp  = 1'b1;
        @(posedge clk); #1;
        pmem_resp  = 1'b0;
      end
      resp = resp_of(d);
      line = line_of(d);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rd_vec_t      vecs[4];
    logic [255:0] exp_line, last_line, line, wl;
    logic [63:0]  base;
    logic [7:0]   resp, exp_resp;
    logic         saw_rd, saw_wr, any_resp;
    int           early_resp;

    vecs[0] = '{0, 32'h0000_1234, 64'h1111_1111_1111_1111, 32'h0000_1220};
    vecs[1] = '{1, 32'hFFFF_FFFF, 64'h0123_4567_89AB_CDEF, 32'hFFFF_FFE0};
    vecs[2] = '{0, 32'h8000_001F, 64'h0F0F_0000_F0F0_0001, 32'h8000_0000};
    vecs[3] = '{1, 32'h0000_0020, 64'h0000_0000_0000_0003, 32'h0000_0020};

    rst = 1'b1;
    req_read0 = '0; req_write0 = '0; req_address0 = '0; req_wdata0 = '0;
    req_read1 = '0; req_write1 = '0; req_address1 = '0; req_wdata1 = '0;
    pmem_rdata = '0; pmem_resp = 1'b0;
    exp_line = '0; last_line = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_pmem_read", 256'(pmem_read0), 256'(0));
    chk("rst_pmem_write", 256'(pmem_write0), 256'(0));
    chk("rst_pmem_address", 256'(pmem_address0), 256'(0));
    chk("rst_pmem_wdata", 256'(pmem_wdata0), 256'(0));
    chk("rst_req_resp", 256'(req_resp0), 256'(0));
    chk("rst_req_rdata", req_rdata0, 256'(0));
    chk("rst_req_resp_p3", 256'(req_resp1), 256'(0));
    chk("rst_pmem_address_p3", 256'(pmem_address1), 256'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    // Table-driven single-port reads with back-to-back beats.
    for (int i = 0; i < 4; i++) begin
      req_address0[32*vecs[i].port +: 32] = vecs[i].addr;
      req_read0[vecs[i].port] = 1'b1;
      @(posedge clk); #1;
      chk($sformatf("rd%0d_pmem_read", i), 256'(pmem_read0), 256'(1));
      chk($sformatf("rd%0d_pmem_write", i), 256'(pmem_write0), 256'(0));
      chk($sformatf("rd%0d_pmem_address", i), 256'(pmem_address0), 256'(vecs[i].exp_addr));
      for (int b = 0; b < 4; b++) begin
        if (b == 3) chk($sformatf("rd%0d_early_resp", i), 256'(req_resp0), 256'(0));
        pmem_rdata = beat_of(vecs[i].base, b);
        exp_line[64*b +: 64] = pmem_rdata;
        pmem_resp = 1'b1;
        @(posedge clk); #1;
        pmem_resp = 1'b0;
      end
      exp_resp = 8'd1 << vecs[i].port;
      chk($sformatf("rd%0d_req_resp", i), 256'(req_resp0), 256'(exp_resp));
      chk($sformatf("rd%0d_req_rdata", i), req_rdata0, exp_line);
      chk($sformatf("rd%0d_done_pmem_read", i), 256'(pmem_read0), 256'(0));
      req_read0 = '0;
      @(posedge clk); #1;
      chk($sformatf("rd%0d_resp_one_cycle", i), 256'(req_resp0), 256'(0));
      chk($sformatf("rd%0d_rdata_held", i), req_rdata0, exp_line);
    end
    last_line = exp_line;

    // Port 1 write with two idle cycles before every beat.
    wl = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
          64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
    req_wdata0[511:256]  = wl;
    req_address0[63:32]  = 32'h8000_0040;
    req_write0           = 2'b10;
    early_resp           = 0;
    @(posedge clk); #1;
    chk("wr_pmem_address", 256'(pmem_address0), 256'(32'h8000_0040));
    for (int b = 0; b < 4; b++) begin
      for (int g = 0; g < 3; g++) begin
        chk($sformatf("wr_b%0d_c%0d_ctl", b, g), 256'({pmem_read0, pmem_write0}), 256'(2'b01));
        chk($sformatf("wr_b%0d_c%0d_wdata", b, g), 256'(pmem_wdata0), 256'(wl[64*b +: 64]));
        if (|req_resp0) early_resp++;
        if (g == 2) begin
          pmem_rdata = '0;
          pmem_resp  = 1'b1;
        end
        @(posedge clk); #1;
        pmem_resp = 1'b0;
      end
    end
    chk("wr_req_resp", 256'(req_resp0), 256'(2'b10));
    chk("wr_no_early_resp", 256'(early_resp), 256'(0));
    req_write0 = '0;
    @(posedge clk); #1;
    chk("wr_resp_once", 256'(req_resp0), 256'(0));
    chk("wr_idle_pmem_write", 256'(pmem_write0), 256'(0));
    chk("wr_rdata_held", req_rdata0, last_line);

    // Round-robin: both ports request continuously, re-requesting after resp.
    req_address0 = {32'h0000_2000, 32'h0000_1000};
    req_read0    = 2'b11;
    for (int k = 0; k < 4; k++) begin
      base = 64'h5A5A_0000_0000_0010 + 64'(k);
      serve(0, base, resp, line, saw_rd, saw_wr);
      for (int b = 0; b < 4; b++) exp_line[64*b +: 64] = beat_of(base, b);
      exp_resp = (k % 2 == 0) ? 8'h01 : 8'h02;
      chk($sformatf("rr_grant%0d", k), 256'(resp), 256'(exp_resp));
      chk($sformatf("rr_line%0d", k), line, exp_line);
      req_read0 = req_read0 & ~resp[1:0];
      @(posedge clk); #1;
      req_read0 = 2'b11;
    end
    req_read0 = '0;
    last_line = exp_line;
    @(posedge clk); #1;

    // Read and write raised together on one port: serviced as a write.
    req_address0[31:0] = 32'h0000_3000;
    req_wdata0[255:0]  = {4{64'hFEED_0000_0000_BEEF}};
    req_read0  = 2'b01;
    req_write0 = 2'b01;
    serve(0, 64'h1, resp, line, saw_rd, saw_wr);
    chk("rw_resp", 256'(resp), 256'(8'h01));
    chk("rw_no_pmem_read", 256'(saw_rd), 256'(0));
    chk("rw_pmem_write", 256'(saw_wr), 256'(1));
    chk("rw_rdata_held", line, last_line);
    req_read0  = '0;
    req_write0 = '0;
    @(posedge clk); #1;

    // Reset after two beats of a read; the aborted transfer never completes.
    req_address0[31:0] = 32'h0000_4000;
    req_read0 = 2'b01;
    @(posedge clk); #1;
    for (int b = 0; b < 2; b++) begin
      pmem_rdata = beat_of(64'h9999, b);
      pmem_resp  = 1'b1;
      @(posedge clk); #1;
      pmem_resp  = 1'b0;
    end
    rst = 1'b1;
    req_read0 = '0;
    @(posedge clk); #1;
    chk("mrst_pmem_read", 256'(pmem_read0), 256'(0));
    chk("mrst_req_resp", 256'(req_resp0), 256'(0));
    rst = 1'b0;
    any_resp = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      any_resp = any_resp | (|req_resp0);
    end
    chk("mrst_no_resp", 256'(any_resp), 256'(0));
    req_address0 = {32'h0000_6000, 32'h0000_5000};
    req_read0    = 2'b11;
    base = 64'h7777_0000_0000_0007;
    serve(0, base, resp, line, saw_rd, saw_wr);
    for (int b = 0; b < 4; b++) exp_line[64*b +: 64] = beat_of(base, b);
    chk("mrst_fresh_grant", 256'(resp), 256'(8'h01));
    chk("mrst_fresh_line", line, exp_line);
    req_read0 = '0;
    @(posedge clk); #1;

    // Fixed priority, 3 ports: 1 and 2 request, 0 joins during port 1's burst.
    req_address1 = {32'h0000_0C00, 32'h0000_0B00, 32'h0000_0A00};
    req_read1    = 3'b110;
    @(posedge clk); #1;
    chk("prio_first_address", 256'(pmem_address1), 256'(32'h0000_0B00));
    chk("prio_read_wdata_zero", 256'(pmem_wdata1), 256'(0));
    req_read1 = 3'b111;
    for (int k = 0; k < 3; k++) begin
      base = 64'h0000_0300_0000_0100 + 64'(k);
      serve(1, base, resp, line, saw_rd, saw_wr);
      for (int b = 0; b < 4; b++) exp_line[64*b +: 64] = beat_of(base, b);
      exp_resp = (k == 0) ? 8'h02 : ((k == 1) ? 8'h01 : 8'h04);
      chk($sformatf("prio_grant%0d", k), 256'(resp), 256'(exp_resp));
      chk($sformatf("prio_line%0d", k), line, exp_line);
      req_read1 = req_read1 & ~resp[2:0];
      @(posedge clk); #1;
    end
    req_read1 = '0;
    @(posedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pmem_burst_arbiter.md
# pmem_burst_arbiter

Parametrised successor to the single-path cache-to-memory link at the `mp4` top level. It arbitrates NUM_PORTS line-granular cache-miss requesters onto one burst physical-memory port. Typical requesters are the I-cache, the D-cache, and later an L2 or prefetcher. Each granted line transfer is serialised into LINE_BITS/BURST_BITS beats. The selectable arbitration mode is new behaviour.

## Interface
- NUM_PORTS, default 2: number of requesters (1–8).
- LINE_BITS, default 256: cacheline width.
- BURST_BITS, default 64: pmem beat width. Must divide LINE_BITS.
- ARB_MODE, default 0: 0 = round-robin, 1 = fixed priority with port 0 highest.
- Derived: BEATS = LINE_BITS/BURST_BITS. OFFSET = log2(LINE_BITS/8).

Ports:
- clk  in  1  clock. All state updates on the rising edge.
- rst  in  1  reset. Synchronous, active-high.
- req_read  in  NUM_PORTS  per-port line read request.
- req_write  in  NUM_PORTS  per-port line write request.
- req_address  in  NUM_PORTS*32  per-port byte address. Port i occupies bits [32i+31:32i].
- req_wdata  in  NUM_PORTS*LINE_BITS  per-port write line.
- req_rdata  out  LINE_BITS  assembled read line. Shared by all ports and qualified by req_resp.
- req_resp  out  NUM_PORTS  one-hot, one-cycle completion pulse.
- pmem_read  out  1  burst read request.
- pmem_write  out  1  burst write request.
- pmem_address  out  32  line-aligned address: {addr[31:OFFSET], OFFSET'b0}.
- pmem_wdata  out  BURST_BITS  current write beat.
- pmem_rdata  in  BURST_BITS  read beat, valid when pmem_resp is high.
- pmem_resp  in  1  beat handshake. One pulse per beat; beats may be non-consecutive.

## Operation
- FSM states: IDLE, READ, WRITE, DONE.
- IDLE:
  - A port requests when its req_read or req_write is high.
  - The winner comes from the arbiter. Its address and op are latched into registers.
  - A port with both bits high is serviced as a write; the read bit is ignored for that grant.
  - Next state is WRITE or READ. With no requests, stay in IDLE.
- Arbiter:
  - Mode 0: search starts at port (last_grant+1) mod NUM_PORTS and takes the first requesting port. last_grant updates on entry to DONE.
  - Mode 1: lowest-index requesting port wins.
- READ:
  - pmem_read is held high.
  - On each pmem_resp, store pmem_rdata into line slice [beat*BURST_BITS +: BURST_BITS] and increment the beat counter.
  - After beat BEATS-1 is received, go to DONE.
- WRITE:
  - pmem_write is held high and pmem_wdata = req_wdata[grant] slice [beat].
  - Each pmem_resp advances the beat. After the last beat, go to DONE.
  - req_wdata of the granted port must stay stable until req_resp.
- DONE:
  - req_resp[grant] = 1 for exactly one cycle. For reads, req_rdata holds the full line this cycle.
  - Next state is IDLE.
  - The requester must drop its request on the edge that ends DONE, so it is not serviced again.
- pmem_read and pmem_write are never high together. Both are low in IDLE and DONE.
- The beat counter is log2(BEATS) bits and clears on entry to READ or WRITE. pmem_resp outside READ/WRITE is ignored.
- Address and op of the granted port are latched at grant. Later changes on that port's inputs do not affect the burst in progress.
- rst in any state:
  - State goes to IDLE, last_grant to NUM_PORTS-1 (so port 0 wins first), and the beat counter to 0.
  - No req_resp is issued for the aborted transfer.

## Timing
- All outputs come from registers or from state decode. No combinational path from pmem_resp to req_resp.
- Reset values: pmem_read=0, pmem_write=0, pmem_address=0, pmem_wdata=0, req_resp=0, req_rdata=0.
- A request first seen in IDLE at cycle t gives pmem_read/pmem_write high at t+1.
- With back-to-back beats at t+1..t+BEATS, req_resp is high at t+BEATS+1. Minimum latency is BEATS+1 cycles (5 for defaults).
- Each extra idle cycle between beats adds one cycle of latency.
- The earliest next grant is sampled in IDLE at t+BEATS+2, so there is one dead IDLE cycle between bursts.
- pmem_address is stable for the whole burst.
- req_rdata holds its last value until the next read completes.

## Test plan
- Single read:
  - Stimulus: port 0 reads 0x0000_1234; memory returns beats 0x11..,0x22..,0x33..,0x44.. back-to-back.
  - Required: pmem_address=0x0000_1220; req_resp=2'b01 5 cycles after the request; req_rdata={0x44..,0x33..,0x22..,0x11..}.
- Write with stalls:
  - Stimulus: port 1 writes line L to 0x8000_0040; memory idles 2 cycles between beats.
  - Required: pmem_wdata shows L[63:0], L[127:64], L[191:128], L[255:192] in order; pmem_write held for the whole burst; req_resp=2'b10 once.
- Round-robin (ARB_MODE=0):
  - Stimulus: ports 0 and 1 request continuously, each re-requesting right after its resp.
  - Required: grants alternate 0,1,0,1. No port is starved.
- Fixed priority (ARB_MODE=1, NUM_PORTS=3):
  - Stimulus: ports 1 and 2 request; port 0 requests during port 1's burst.
  - Required: grant order is 1, 0, 2.
- Mid-burst reset:
  - Stimulus: rst asserted after beat 2 of a read.
  - Required: pmem_read=0 the next cycle; no req_resp; a fresh request afterwards completes normally with the beat counter restarted at 0.
- Read+write on one port:
  - Stimulus: port 0 raises req_read and req_write together.
  - Required: a write burst; pmem_read never goes high.
